// File: rtl/vhls_double4.sv
// Streaming doubling kernel: pops COUNT words from the input FIFO, doubles each
// (x2 truncated to WIDTH) and pushes the results to the output FIFO in order.
// A sticky valid flag reports completion until the next reset.
module vhls_double4 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] arg_0_out_data,
  input  logic             arg_0_read_ready,
  output logic             arg_0_read_valid,
  input  logic             arg_0_write_ready,
  output logic             arg_0_rst,
  output logic [WIDTH-1:0] arg_1_in_data,
  output logic             arg_1_write_valid,
  input  logic             arg_1_write_ready,
  input  logic [WIDTH-1:0] arg_1_out_data,
  input  logic             arg_1_read_ready,
  output logic             arg_1_rst,
  output logic             valid
);

  localparam int unsigned CntW = $clog2(COUNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(COUNT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StReadReq,
    StReadCapture,
    StWrite,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;

  // Inputs the kernel never looks at; the doubled word drops the input MSB.
  logic unused_inputs;
  assign unused_inputs = ^{arg_0_write_ready, arg_1_out_data, arg_1_read_ready,
                           arg_0_out_data[WIDTH-1]};

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StReadReq;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and FIFO handshake decode.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    data_d            = data_q;
    valid_d           = valid_q;
    arg_0_read_valid  = 1'b0;
    arg_1_write_valid = 1'b0;
    case (state_q)
      StReadReq: begin
        if (cnt_q == CntMax) begin
          state_d = StDone;
        end else begin
          // Gated by rst so no pop escapes while the kernel is held in reset.
          arg_0_read_valid = arg_0_read_ready & rst;
          if (arg_0_read_ready) begin
            state_d = StReadCapture;
          end
        end
      end
      StReadCapture: begin
        // Popped word is on out_data the cycle after the pop edge.
        data_d  = {arg_0_out_data[WIDTH-2:0], 1'b0};
        state_d = StWrite;
      end
      StWrite: begin
        arg_1_write_valid = 1'b1;
        if (arg_1_write_ready) begin
          cnt_d   = cnt_q + CntOne;
          state_d = StReadReq;
          if (cnt_q == CntMax - CntOne) begin
            valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        valid_d = 1'b1;
      end
      default: begin
        state_d = StReadReq;
      end
    endcase
  end

  assign arg_1_in_data = data_q;
  assign arg_0_rst     = 1'b0;
  assign arg_1_rst     = 1'b0;
  assign valid         = valid_q;

endmodule

// File: tb/tb_vhls_double4.sv
// Directed bench for vhls_double4 with behavioural models of both FIFOs.
module tb_vhls_double4;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] arg_0_out_data;
  logic             arg_0_read_ready;
  logic             arg_0_read_valid;
  logic             arg_0_write_ready;
  logic             arg_0_rst;
  logic [WIDTH-1:0] arg_1_in_data;
  logic             arg_1_write_valid;
  logic             arg_1_write_ready;
  logic [WIDTH-1:0] arg_1_out_data;
  logic             arg_1_read_ready;
  logic             arg_1_rst;
  logic             valid;

  int tests = 0;
  int fails = 0;

  // Input FIFO model: initial block owns wr_ptr/in_mem, model owns rd_ptr.
  logic [WIDTH-1:0] in_mem [64];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  // Output FIFO model.
  logic [WIDTH-1:0] out_mem [64];
  int               out_wr = 0;
  logic             flush = 1'b0;
  logic             bad_pop = 1'b0;

  vhls_double4 #(.WIDTH(16), .COUNT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .arg_0_out_data    (arg_0_out_data),
    .arg_0_read_ready  (arg_0_read_ready),
    .arg_0_read_valid  (arg_0_read_valid),
    .arg_0_write_ready (arg_0_write_ready),
    .arg_0_rst         (arg_0_rst),
    .arg_1_in_data     (arg_1_in_data),
    .arg_1_write_valid (arg_1_write_valid),
    .arg_1_write_ready (arg_1_write_ready),
    .arg_1_out_data    (arg_1_out_data),
    .arg_1_read_ready  (arg_1_read_ready),
    .arg_1_rst         (arg_1_rst),
    .valid             (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign arg_0_read_ready  = (wr_ptr != rd_ptr);
  assign arg_0_write_ready = 1'b1;
  assign arg_1_out_data    = '0;
  assign arg_1_read_ready  = (out_wr != 0);

  initial arg_0_out_data = '0;

  // FIFO models: registered pop data, push on valid && ready.
  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
      out_wr <= 0;
    end else begin
      if (arg_0_read_valid && !arg_0_read_ready) bad_pop <= 1'b1;
      if (arg_0_read_valid && arg_0_read_ready) begin
        arg_0_out_data <= in_mem[rd_ptr];
        rd_ptr         <= rd_ptr + 1;
      end
      if (arg_1_write_valid && arg_1_write_ready) begin
        out_mem[out_wr] <= arg_1_in_data;
        out_wr          <= out_wr + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_in(input logic [WIDTH-1:0] w);
    in_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    int k = 0;
    while (out_wr < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(out_wr >= n), 32'd1);
  endtask

  task automatic check_outs(input string tag, input logic [WIDTH-1:0] e0,
                            input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                            input logic [WIDTH-1:0] e3);
    check({tag, "_count"}, 32'(out_wr), 32'd4);
    check({tag, "_w0"}, 32'(out_mem[0]), 32'(e0));
    check({tag, "_w1"}, 32'(out_mem[1]), 32'(e1));
    check({tag, "_w2"}, 32'(out_mem[2]), 32'(e2));
    check({tag, "_w3"}, 32'(out_mem[3]), 32'(e3));
  endtask

  initial begin
    rst = 1'b1;
    arg_1_write_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    // Outputs during reset.
    check("rst_read_valid", 32'(arg_0_read_valid), 32'd0);
    check("rst_write_valid", 32'(arg_1_write_valid), 32'd0);
    check("rst_in_data", 32'(arg_1_in_data), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_arg0_rst", 32'(arg_0_rst), 32'd0);
    check("rst_arg1_rst", 32'(arg_1_rst), 32'd0);

    // Basic run; first word arrives while reset is still held.
    @(negedge clk);
    push_in(16'd28);
    #1;
    check("rst_no_pop", 32'(arg_0_read_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_valid", 32'(valid), 32'd0);
    rst = 1'b1;
    @(negedge clk); push_in(16'd10);
    @(negedge clk); push_in(16'd7);
    @(negedge clk); push_in(16'd3);
    @(negedge clk);
    @(negedge clk); push_in(16'd9);
    repeat (700) @(negedge clk);
    check("basic_valid", 32'(valid), 32'd1);
    check_outs("basic", 16'd56, 16'd20, 16'd14, 16'd6);
    check("basic_left", 32'(wr_ptr - rd_ptr), 32'd1);
    check("basic_left_word", 32'(in_mem[rd_ptr]), 32'd9);

    // Sparse input, one word every 20 cycles; includes 0x8000 -> 0.
    reset_dut();
    check("sparse_valid_rst", 32'(valid), 32'd0);
    push_in(16'h8000);
    repeat (20) @(negedge clk);
    push_in(16'h0005);
    repeat (20) @(negedge clk);
    push_in(16'h4000);
    repeat (20) @(negedge clk);
    check("sparse_valid_early", 32'(valid), 32'd0);
    check("sparse_out3", 32'(out_wr), 32'd3);
    push_in(16'h1234);
    wait_out("sparse_wait", 4, 40);
    repeat (3) @(negedge clk);
    check("sparse_valid", 32'(valid), 32'd1);
    check_outs("sparse", 16'h0000, 16'h000A, 16'h8000, 16'h2468);
    check("sparse_no_bad_pop", 32'(bad_pop), 32'd0);

    // Output back-pressure during the second word.
    reset_dut();
    push_in(16'd28); push_in(16'd10); push_in(16'd7); push_in(16'd3);
    wait_out("stall_wait1", 1, 40);
    arg_1_write_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_data_a", 32'(arg_1_in_data), 32'd20);
    check("stall_wv_a", 32'(arg_1_write_valid), 32'd1);
    repeat (5) @(negedge clk);
    check("stall_data_b", 32'(arg_1_in_data), 32'd20);
    check("stall_wv_b", 32'(arg_1_write_valid), 32'd1);
    check("stall_out1", 32'(out_wr), 32'd1);
    check("stall_valid", 32'(valid), 32'd0);
    arg_1_write_ready = 1'b1;
    wait_out("stall_wait4", 4, 60);
    repeat (3) @(negedge clk);
    check("stall_valid_end", 32'(valid), 32'd1);
    check_outs("stall", 16'd56, 16'd20, 16'd14, 16'd6);

    // Truncation at the word boundaries.
    reset_dut();
    push_in(16'h8001); push_in(16'h7FFF); push_in(16'h0000); push_in(16'h0001);
    wait_out("trunc_wait", 4, 60);
    repeat (3) @(negedge clk);
    check("trunc_valid", 32'(valid), 32'd1);
    check_outs("trunc", 16'h0002, 16'hFFFE, 16'h0000, 16'h0002);

    // Reset mid-run, then a fresh run with new words.
    check("abort_valid_before", 32'(valid), 32'd1);
    reset_dut();
    check("abort_valid_clear", 32'(valid), 32'd0);
    push_in(16'd1); push_in(16'd2); push_in(16'd3); push_in(16'd4);
    wait_out("abort_wait2", 2, 40);
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_wv", 32'(arg_1_write_valid), 32'd0);
    check("abort_rv", 32'(arg_0_read_valid), 32'd0);
    check("abort_data", 32'(arg_1_in_data), 32'd0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push_in(16'h0011); push_in(16'h0022); push_in(16'h0033); push_in(16'h0044);
    wait_out("abort_wait4", 4, 60);
    repeat (3) @(negedge clk);
    check("abort_valid_end", 32'(valid), 32'd1);
    check_outs("abort", 16'h0022, 16'h0044, 16'h0066, 16'h0088);
    check("final_no_bad_pop", 32'(bad_pop), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
